// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with dual write, zero register, bypass
// and a per-register pending-write scoreboard with outstanding-write count.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    output logic [NUM_RD-1:0]          rdPending,
    input  logic                       wrEnbA,
    input  logic [ADDR_W-1:0]          wrAddrA,
    input  logic [DATA_W-1:0]          wrDataA,
    input  logic                       wrEnbB,
    input  logic [ADDR_W-1:0]          wrAddrB,
    input  logic [DATA_W-1:0]          wrDataB,
    input  logic                       issueEnb,
    input  logic [ADDR_W-1:0]          issueAddr,
    output logic                       issueConflict,
    output logic [ADDR_W:0]            pendCount
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending, pend_nxt;
    logic              wa_ok, wb_ok, iss_ok;
    logic              inc, dec_a, dec_b;

    // Writes and issues aimed at the hardwired zero register are discarded up front.
    assign wa_ok  = wrEnbA   && !(ZERO_REG != 0 && wrAddrA   == '0);
    assign wb_ok  = wrEnbB   && !(ZERO_REG != 0 && wrAddrB   == '0);
    assign iss_ok = issueEnb && !(ZERO_REG != 0 && issueAddr == '0);

    assign issueConflict = iss_ok && pending[issueAddr];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              ha, hb, zero;
        assign a    = rdAddr[k*ADDR_W +: ADDR_W];
        assign zero = ZERO_REG != 0 && a == '0;
        assign ha   = BYPASS != 0 && wa_ok && wrAddrA == a;
        assign hb   = BYPASS != 0 && wb_ok && wrAddrB == a;
        assign rdData[k*DATA_W +: DATA_W] = zero ? '0 : hb ? wrDataB : ha ? wrDataA : regs[a];
        assign rdPending[k] = pending[a] && !(ha || hb);
    end

    // Clears first, then set, so a same-cycle issue keeps the register pending.
    always_comb begin
        pend_nxt = pending;
        if (wa_ok) pend_nxt[wrAddrA] = 1'b0;
        if (wb_ok) pend_nxt[wrAddrB] = 1'b0;
        if (iss_ok) pend_nxt[issueAddr] = 1'b1;
    end

    // Count only real transitions; a clear of a register being re-issued, or the
    // second port hitting the same register, must not decrement again.
    assign inc   = iss_ok && !pending[issueAddr];
    assign dec_a = wa_ok && pending[wrAddrA] && !(iss_ok && issueAddr == wrAddrA);
    assign dec_b = wb_ok && pending[wrAddrB] && !(iss_ok && issueAddr == wrAddrB)
                   && !(wa_ok && wrAddrA == wrAddrB);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pending   <= '0;
            pendCount <= '0;
        end else begin
            if (wa_ok) regs[wrAddrA] <= wrDataA;
            if (wb_ok) regs[wrAddrB] <= wrDataB;
            pending   <= pend_nxt;
            pendCount <= pendCount + CW'(inc) - CW'(dec_a) - CW'(dec_b);
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of two regfile_mp configurations
// (zero-reg+bypass, and plain without bypass) against an array-based model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rd_addr;
    logic        wea, web, ie;
    logic [3:0]  wra, wrb, ia;
    logic [63:0] wda, wdb;
    logic [255:0] rdd0, rdd1;
    logic [3:0]  rdp0, rdp1;
    logic        conf0, conf1;
    logic [4:0]  cnt0, cnt1;

    logic [63:0] m_regs [2][16];
    bit          m_pend [2][16];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .rdAddr(rd_addr), .rdData(rdd0), .rdPending(rdp0),
        .wrEnbA(wea), .wrAddrA(wra), .wrDataA(wda),
        .wrEnbB(web), .wrAddrB(wrb), .wrDataB(wdb),
        .issueEnb(ie), .issueAddr(ia), .issueConflict(conf0), .pendCount(cnt0));

    regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .rdAddr(rd_addr), .rdData(rdd1), .rdPending(rdp1),
        .wrEnbA(wea), .wrAddrA(wra), .wrDataA(wda),
        .wrEnbB(web), .wrAddrB(wrb), .wrDataB(wdb),
        .issueEnb(ie), .issueAddr(ia), .issueConflict(conf1), .pendCount(cnt1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Config 0 has the zero register; config 0 also bypasses.
    function automatic bit valid(int c, bit en, logic [3:0] a);
        return en && !(c == 0 && a == 4'd0);
    endfunction

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            bit zr = (c == 0);
            bit bp = (c == 0);
            int cnt = 0;
            for (int r = 0; r < 16; r++) cnt += int'(m_pend[c][r]);
            for (int k = 0; k < 4; k++) begin
                logic [3:0]  a = rd_addr[k*4 +: 4];
                bit          hit_a = bp && valid(c, wea, wra) && wra == a;
                bit          hit_b = bp && valid(c, web, wrb) && wrb == a;
                logic [63:0] ed;
                bit          ep;
                if (zr && a == 4'd0) begin
                    ed = 64'd0;
                    ep = 1'b0;
                end else begin
                    ed = hit_b ? wdb : hit_a ? wda : m_regs[c][a];
                    ep = m_pend[c][a] && !(hit_a || hit_b);
                end
                chk($sformatf("c%0d_data%0d", c, k), c == 0 ? rdd0[k*64 +: 64] : rdd1[k*64 +: 64], ed);
                chk($sformatf("c%0d_pend%0d", c, k), 64'(c == 0 ? rdp0[k] : rdp1[k]), 64'(ep));
            end
            chk($sformatf("c%0d_conflict", c), 64'(c == 0 ? conf0 : conf1),
                64'(valid(c, ie, ia) && m_pend[c][ia]));
            chk($sformatf("c%0d_count", c), 64'(c == 0 ? cnt0 : cnt1), 64'(cnt));
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int r = 0; r < 16; r++) begin
                    m_regs[c][r] = 64'd0;
                    m_pend[c][r] = 1'b0;
                end
            end else begin
                if (valid(c, wea, wra)) begin m_regs[c][wra] = wda; m_pend[c][wra] = 1'b0; end
                if (valid(c, web, wrb)) begin m_regs[c][wrb] = wdb; m_pend[c][wrb] = 1'b0; end
                if (valid(c, ie, ia)) m_pend[c][ia] = 1'b1;
            end
        end
    endtask

    // Inputs are set just after an edge; outputs are checked 1 time unit later.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; wea = 0; web = 0; ie = 0;
        wra = 0; wrb = 0; ia = 0; wda = 0; wdb = 0;
    endtask

    initial begin
        idle();
        rd_addr = 16'h0000;
        @(posedge clk); #1;
        // Reset overrides a same-cycle write
        rst = 1; wea = 1; wra = 4'd3; wda = 64'hFFFF_FFFF;
        rd_addr = 16'h0003;
        cyc();
        idle();
        #1;
        chk("rst_rd3", rdd0[63:0], 64'd0);
        chk("rst_count", 64'(cnt0), 64'd0);
        cyc();
        // Dual write collision on r5: B wins; bypass shows B, no-bypass shows old
        wea = 1; wra = 4'd5; wda = 64'h11; web = 1; wrb = 4'd5; wdb = 64'h22;
        rd_addr = 16'h0005;
        #1;
        chk("coll_byp", rdd0[63:0], 64'h22);
        chk("coll_nobyp", rdd1[63:0], 64'h0);
        cyc();
        idle();
        #1;
        chk("coll_after0", rdd0[63:0], 64'h22);
        chk("coll_after1", rdd1[63:0], 64'h22);
        cyc();
        // Zero register ignores write and issue
        wea = 1; wra = 4'd0; wda = 64'hDEAD; rd_addr = 16'h0000;
        cyc();
        idle(); ie = 1; ia = 4'd0;
        #1;
        chk("zero_conflict", 64'(conf0), 64'd0);
        cyc();
        idle();
        #1;
        chk("zero_rd", rdd0[63:0], 64'd0);
        chk("zero_pend", 64'(rdp0[0]), 64'd0);
        chk("zero_count", 64'(cnt0), 64'd0);
        cyc();
        // Scoreboard on r7, then issue+write r8 together
        ie = 1; ia = 4'd7; rd_addr = 16'h0007;
        cyc();
        #1;
        chk("sb_cnt1", 64'(cnt0), 64'd1);
        chk("sb_conflict", 64'(conf0), 64'd1);
        cyc();
        idle(); wea = 1; wra = 4'd7; wda = 64'h77;
        #1;
        chk("sb_cnt_still1", 64'(cnt0), 64'd1);
        chk("sb_byp_pend", 64'(rdp0[0]), 64'd0);
        cyc();
        idle(); ie = 1; ia = 4'd8; wea = 1; wra = 4'd8; wda = 64'h88;
        #1;
        chk("sb_cnt0", 64'(cnt0), 64'd0);
        cyc();
        idle(); rd_addr = 16'h0008;
        #1;
        chk("sb_r8_pend", 64'(rdp0[0]), 64'd1);
        chk("sb_r8_cnt", 64'(cnt0), 64'd1);
        cyc();
        // Double clear of r9/r10 (clear r8 first)
        idle(); wea = 1; wra = 4'd8; ie = 1; ia = 4'd9;
        cyc();
        idle(); ie = 1; ia = 4'd10;
        cyc();
        idle(); wea = 1; wra = 4'd9; web = 1; wrb = 4'd10;
        #1;
        chk("dc_cnt2", 64'(cnt0), 64'd2);
        cyc();
        idle(); wea = 1; wra = 4'd11;
        #1;
        chk("dc_cnt0", 64'(cnt0), 64'd0);
        cyc();
        idle();
        #1;
        chk("dc_nonpend", 64'(cnt0), 64'd0);
        cyc();
        // Random sweep with occasional resets
        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            wea = $urandom_range(0, 1) == 1; wra = 4'($urandom);
            web = $urandom_range(0, 2) == 0; wrb = 4'($urandom);
            wda = {$urandom, $urandom}; wdb = {$urandom, $urandom};
            ie = $urandom_range(0, 1) == 1; ia = 4'($urandom);
            rd_addr = 16'($urandom);
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
